// File: rtl/frame_decoder_if.sv
// LED frame decoder bundle: sampled LED pattern in, recovered frame index and status out.
// The master modport drives led/led_vld; the slave modport is the decoder.
interface frame_decoder_if #(
  parameter int ERR_CNT_W = 8
);
  logic [15:0]          led;
  logic                 led_vld;
  logic [4:0]           fm_no;
  logic                 fm_vld;
  logic                 locked;
  logic                 pat_err;
  logic                 seq_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output led, led_vld,
    input  fm_no, fm_vld, locked, pat_err, seq_err, err_cnt
  );

  modport slave (
    input  led, led_vld,
    output fm_no, fm_vld, locked, pat_err, seq_err, err_cnt
  );
endinterface

// File: rtl/frame_decoder.sv
// Recovers the 5-bit frame index from a 16-bit thermometer LED pattern; all outputs 1 cycle after led_vld.
// No backpressure. FRAME_DECODER_REPEAT_TOL_EN tolerates repeated frames while locked.
module frame_decoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  frame_decoder_if.slave  bus
);

  typedef enum logic [1:0] {SYNC, ACQ, LOCK} state_t;

  state_t               r_state;
  logic [4:0]           r_k_prev;
  logic [4:0]           r_fm_no;
  logic                 r_fm_vld;
  logic                 r_pat_err;
  logic                 r_seq_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic [4:0] w_k;
  logic       w_legal;
  logic [4:0] w_e;
  logic [4:0] w_ke;
  logic       w_repeat;
  logic       w_pat_ev;
  logic       w_seq_ev;
  logic       w_sync_eval;
  logic       w_acq_up;
  logic       w_acq_dn;

  // Number of lit LEDs for a frame: fill phase 0..16, then drain back down.
  function automatic logic [4:0] frame_cnt(input logic [4:0] f);
    frame_cnt = (f <= 5'd16) ? f : 5'(6'd32 - {1'b0, f});
  endfunction

  always_comb begin
    w_k = '0;
    for (int i = 0; i < 16; i++) begin
      w_k = w_k + {4'd0, bus.led[i]};
    end
  end

  assign w_legal = (bus.led == ~(16'hFFFF >> w_k));
  assign w_e     = r_fm_no + 5'd1;
  assign w_ke    = frame_cnt(w_e);

`ifdef FRAME_DECODER_REPEAT_TOL_EN
  logic [4:0] w_cur_k;
  assign w_cur_k  = frame_cnt(r_fm_no);
  assign w_repeat = (w_k == w_cur_k);
`else
  assign w_repeat = 1'b0;
`endif

  assign w_acq_up    = (w_k == r_k_prev + 5'd1);
  assign w_acq_dn    = (w_k == r_k_prev - 5'd1);
  assign w_sync_eval = (r_state == SYNC) || ((r_state == ACQ) && !w_acq_up && !w_acq_dn);
  assign w_pat_ev    = bus.led_vld && !w_legal;
  assign w_seq_ev    = bus.led_vld && w_legal && (r_state == LOCK) && (w_k != w_ke) && !w_repeat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= SYNC;
      r_k_prev  <= '0;
      r_fm_no   <= '0;
      r_fm_vld  <= 1'b0;
      r_pat_err <= 1'b0;
      r_seq_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_fm_vld  <= 1'b0;
      r_pat_err <= 1'b0;
      r_seq_err <= 1'b0;
      if (bus.led_vld) begin
        if (!w_legal) begin
          r_pat_err <= 1'b1;
          r_state   <= SYNC;
        end else if (w_sync_eval) begin
          // Only the all-dark and all-lit frames identify the position on their own.
          if (w_k == 5'd0 || w_k == 5'd16) begin
            r_fm_no  <= w_k;
            r_fm_vld <= 1'b1;
            r_state  <= LOCK;
          end else begin
            r_k_prev <= w_k;
            r_state  <= ACQ;
          end
        end else if (r_state == ACQ) begin
          r_fm_no  <= w_acq_up ? w_k : 5'(6'd32 - {1'b0, w_k});
          r_fm_vld <= 1'b1;
          r_state  <= LOCK;
        end else if (r_state == LOCK) begin
          if (w_k == w_ke) begin
            r_fm_no  <= w_e;
            r_fm_vld <= 1'b1;
          end else if (w_seq_ev) begin
            r_seq_err <= 1'b1;
            r_state   <= SYNC;
          end
        end else begin
          r_state <= SYNC;
        end
      end
      if ((w_pat_ev || w_seq_ev) && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign bus.fm_no   = r_fm_no;
  assign bus.fm_vld  = r_fm_vld;
  assign bus.locked  = (r_state == LOCK);
  assign bus.pat_err = r_pat_err;
  assign bus.seq_err = r_seq_err;
  assign bus.err_cnt = r_err_cnt;

endmodule

// File: tb/tb_frame_decoder.sv
// Scoreboard bench for frame_decoder: driver pushes model predictions, monitor pops and compares each cycle.
module tb_frame_decoder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_decoder_if #(.ERR_CNT_W(W)) bus ();
  frame_decoder #(.ERR_CNT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [4:0]   fm_no;
    logic         fm_vld;
    logic         locked;
    logic         pat_err;
    logic         seq_err;
    logic [W-1:0] err_cnt;
  } exp_t;

  exp_t q[$];
  exp_t got;
  exp_t want;
  int vectors = 0;
  int miscompares = 0;

  localparam int M_SYNC = 0, M_ACQ = 1, M_LOCK = 2;
  int m_mode = M_SYNC;
  int m_kprev = 0;
  int m_fm = 0;
  int m_err = 0;

  function automatic int fcnt(input int f);
    return (f <= 16) ? f : 32 - f;
  endfunction

  function automatic logic [15:0] therm(input int c);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < c; i++) p[15-i] = 1'b1;
    return p;
  endfunction

  task automatic model(input logic r, input logic v, input logic [15:0] d);
    exp_t e;
    int k;
    e = '0;
    if (r) begin
      m_mode = M_SYNC; m_kprev = 0; m_fm = 0; m_err = 0;
    end else if (v) begin
      k = -1;
      for (int c = 0; c <= 16; c++) if (d == therm(c)) k = c;
      if (k < 0) begin
        e.pat_err = 1'b1; m_mode = M_SYNC; m_err++;
      end else begin
        if (m_mode == M_ACQ && k == m_kprev + 1) begin
          m_fm = k; e.fm_vld = 1'b1; m_mode = M_LOCK;
        end else if (m_mode == M_ACQ && k == m_kprev - 1) begin
          m_fm = (32 - k) % 32; e.fm_vld = 1'b1; m_mode = M_LOCK;
        end else if (m_mode == M_LOCK) begin
          if (k == fcnt((m_fm + 1) % 32)) begin
            m_fm = (m_fm + 1) % 32; e.fm_vld = 1'b1;
          end
`ifdef FRAME_DECODER_REPEAT_TOL_EN
          else if (k == fcnt(m_fm)) begin
          end
`endif
          else begin
            e.seq_err = 1'b1; m_mode = M_SYNC; m_err++;
          end
        end else if (k == 0 || k == 16) begin
          m_fm = k; e.fm_vld = 1'b1; m_mode = M_LOCK;
        end else begin
          m_kprev = k; m_mode = M_ACQ;
        end
      end
      if (m_err > (1 << W) - 1) m_err = (1 << W) - 1;
    end
    e.fm_no   = 5'(m_fm);
    e.locked  = (m_mode == M_LOCK);
    e.err_cnt = W'(m_err);
    q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic v, input logic [15:0] d);
    @(negedge clk);
    rst = r;
    bus.led_vld = v;
    bus.led = d;
    model(r, v, d);
  endtask

  task automatic frame(input int f);
    drive(1'b0, 1'b1, therm(fcnt(f)));
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'($urandom));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        want = q.pop_front();
        got = {bus.fm_no, bus.fm_vld, bus.locked, bus.pat_err, bus.seq_err, bus.err_cnt};
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL outputs @%0t: got fm_no=%0d vld=%b lck=%b pe=%b se=%b cnt=%0d, want fm_no=%0d vld=%b lck=%b pe=%b se=%b cnt=%0d",
                   $time, got.fm_no, got.fm_vld, got.locked, got.pat_err, got.seq_err, got.err_cnt,
                   want.fm_no, want.fm_vld, want.locked, want.pat_err, want.seq_err, want.err_cnt);
        end
      end
    end
  end

  initial begin
    int r;
    bus.led_vld = 1'b0;
    bus.led = '0;
    drive(1'b1, 1'b0, 16'h0);
    drive(1'b1, 1'b1, 16'h8000);
    frame(0);
    for (int f = 1; f <= 32; f++) begin
      frame(f % 32);
      if (($urandom & 3) == 0) idle();
    end
    // Acquire from a falling pair: 3 lit then 2 lit means frame 30.
    drive(1'b1, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 16'hE000);
    drive(1'b0, 1'b1, 16'hC000);
    drive(1'b1, 1'b0, 16'h0);
    frame(0);
    for (int f = 1; f <= 5; f++) frame(f);
    drive(1'b0, 1'b1, 16'hFF00);
    drive(1'b0, 1'b1, 16'h8001);
    frame(0);
    for (int f = 1; f <= 3; f++) frame(f);
    drive(1'b0, 1'b1, 16'hE000);
    drive(1'b0, 1'b1, 16'hE000);
    frame(4);
    drive(1'b1, 1'b1, 16'h0000);
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      frame((m_fm + 1) % 32);
      else if (r < 70) drive(1'b0, 1'b1, therm($urandom_range(0, 16)));
      else if (r < 78) drive(1'b0, 1'b1, 16'($urandom));
      else if (r < 85) frame(m_fm);
      else if (r < 97) idle();
      else             drive(1'b1, ($urandom & 1) == 1, 16'($urandom));
    end
    for (int i = 0; i < (1 << W) + 3; i++) drive(1'b0, 1'b1, 16'h8001);
    frame(0);
    idle();
    idle();
    repeat (5) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
